// File: rtl/cb_cfg_pkg.sv
// Shared types and helpers for the cbx_1__0_ configuration loader.
//   cfg_state_e  : sequencer states (off, idle, setup, pulse, hold, done)
//   timer_width  : counter width needed to hold the largest phase length minus one
//   TIMER_W      : timer width for the default phase timing
//   slice_base   : first bl/wl bit of a mux's config slice
package cb_cfg_pkg;

   typedef enum logic [2:0] {
      StOff,
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StDone
   } cfg_state_e;

   localparam int unsigned DEF_SETUP_CYC = 1;
   localparam int unsigned DEF_PULSE_CYC = 2;
   localparam int unsigned DEF_HOLD_CYC  = 1;

   // The timer is loaded with (cycles - 1), so clog2(max) bits suffice; never narrower than 1.
   function automatic int unsigned timer_width(input int unsigned setup_cyc,
                                               input int unsigned pulse_cyc,
                                               input int unsigned hold_cyc);
      int unsigned m;
      m = setup_cyc;
      if (pulse_cyc > m) m = pulse_cyc;
      if (hold_cyc > m) m = hold_cyc;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

   localparam int unsigned TIMER_W = timer_width(DEF_SETUP_CYC, DEF_PULSE_CYC, DEF_HOLD_CYC);

   function automatic int unsigned slice_base(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/cb_cfg_timer.sv
// Loadable down-counter shared by the setup/pulse/hold phases.
//   prog_clk   : clock, rising edge
//   prog_reset : synchronous active-high reset, clears the count
//   load       : load load_val this cycle (wins over counting)
//   load_val   : value to load (phase length minus one)
//   en         : count down while non-zero
//   zero       : count is zero
module cb_cfg_timer
   import cb_cfg_pkg::*;
#(
   parameter int unsigned WIDTH = TIMER_W
) (
   input  logic             prog_clk,
   input  logic             prog_reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/cb_cfg_loader.sv
// Memory-bank configuration sequencer for connection block cbx_1__0_.
// Takes one mux config word per valid/ready handshake, drives it onto that mux's bl slice and
// pulses the mux's wl slice with programmable setup/pulse/hold timing.
//   prog_clk    : programming clock, all state on rising edge
//   prog_reset  : synchronous active-high reset
//   cfg_start   : one-cycle pulse, opens a session and clears the word index
//   cfg_data    : config word for the current mux, bit 0 -> sram[0]
//   cfg_valid   : cfg_data valid
//   cfg_ready   : a word is accepted this cycle when cfg_valid is also high
//   bl, wl      : flat bit/word lines, indexed [0:NUM_MUX*MUX_SRAM-1] as in the CB
//   cfg_mux_idx : mux being / next to be written
//   cfg_busy    : session open and not done
//   cfg_done    : sticky, all NUM_MUX words written
module cb_cfg_loader
   import cb_cfg_pkg::*;
#(
   parameter int unsigned NUM_MUX   = 11,
   parameter int unsigned MUX_SRAM  = 6,
   parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
   parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
   parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic                          prog_clk,
   input  logic                          prog_reset,
   input  logic                          cfg_start,
   input  logic [MUX_SRAM-1:0]           cfg_data,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   output logic [0:NUM_MUX*MUX_SRAM-1]   bl,
   output logic [0:NUM_MUX*MUX_SRAM-1]   wl,
   output logic [3:0]                    cfg_mux_idx,
   output logic                          cfg_busy,
   output logic                          cfg_done
);

   localparam int unsigned TW     = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam int unsigned NBITS  = NUM_MUX * MUX_SRAM;
   localparam int unsigned BASE_W = (NBITS <= 2) ? 1 : $clog2(NBITS);

   localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYC - 1);
   localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYC - 1);
   localparam logic [3:0]    LAST_IDX   = 4'(NUM_MUX - 1);

   // cfg_mux_idx is 4 bits and must be able to show NUM_MUX once the session is done.
   if (NUM_MUX < 1 || NUM_MUX > 15) begin : g_num_mux_check
      $error("cb_cfg_loader: NUM_MUX must be in 1..15");
   end
   if (MUX_SRAM < 1 || SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_cyc_check
      $error("cb_cfg_loader: MUX_SRAM and all phase lengths must be >= 1");
   end

   cfg_state_e          state_q, state_d;
   logic [3:0]          idx_q, idx_d;
   logic [MUX_SRAM-1:0] data_q, data_d;
   logic                timer_load;
   logic [TW-1:0]       timer_val;
   logic                timer_en;
   logic                timer_zero;
   logic [BASE_W-1:0]   base;

   cb_cfg_timer #(
      .WIDTH (TW)
   ) u_timer (
      .prog_clk   (prog_clk),
      .prog_reset (prog_reset),
      .load       (timer_load),
      .load_val   (timer_val),
      .en         (timer_en),
      .zero       (timer_zero)
   );

   assign timer_en = (state_q inside {StSetup, StPulse, StHold});

   // State register.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q <= StOff;
         idx_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
      end
   end

   // Next state. cfg_start is ignored while a write is in flight so bl/wl timing is never cut.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      data_d     = data_q;
      timer_load = 1'b0;
      timer_val  = '0;
      unique case (state_q)
         StOff: begin
            if (cfg_start) begin
               state_d = StIdle;
               idx_d   = '0;
            end
         end
         StIdle: begin
            if (cfg_start) begin
               // Start beats a coincident transfer: the word is dropped.
               idx_d = '0;
            end else if (cfg_valid) begin
               data_d     = cfg_data;
               timer_load = 1'b1;
               timer_val  = SETUP_LOAD;
               state_d    = StSetup;
            end
         end
         StSetup: begin
            if (timer_zero) begin
               timer_load = 1'b1;
               timer_val  = PULSE_LOAD;
               state_d    = StPulse;
            end
         end
         StPulse: begin
            if (timer_zero) begin
               timer_load = 1'b1;
               timer_val  = HOLD_LOAD;
               state_d    = StHold;
            end
         end
         StHold: begin
            if (timer_zero) begin
               data_d  = '0;
               idx_d   = idx_q + 4'd1;
               state_d = (idx_q == LAST_IDX) ? StDone : StIdle;
            end
         end
         StDone: begin
            if (cfg_start) begin
               state_d = StIdle;
               idx_d   = '0;
            end
         end
         default: state_d = StOff;
      endcase
   end

   // Outputs, decoded from registered state only.
   always_comb begin
      cfg_ready   = (state_q == StIdle);
      cfg_busy    = (state_q != StOff) && (state_q != StDone);
      cfg_done    = (state_q == StDone);
      cfg_mux_idx = idx_q;
      bl          = '0;
      wl          = '0;
      base        = BASE_W'(slice_base(32'(idx_q), MUX_SRAM));
      // bl is held for the whole write so wl only ever rises/falls on a stable bl.
      if (state_q inside {StSetup, StPulse, StHold}) begin
         for (int i = 0; i < int'(MUX_SRAM); i++) begin
            bl[base + BASE_W'(i)] = data_q[i];
         end
      end
      if (state_q == StPulse) begin
         for (int i = 0; i < int'(MUX_SRAM); i++) begin
            wl[base + BASE_W'(i)] = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cb_cfg_loader.sv
module tb_cb_cfg_loader;

   localparam int N    = 11;
   localparam int W    = 6;
   localparam int NB   = N * W;
   localparam int LAT  = 5;   // setup + pulse + hold + 1 with default timing
   localparam int PLEN = 2;

   logic          prog_clk = 1'b0;
   logic          prog_reset = 1'b1;
   logic          cfg_start = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [W-1:0]  cfg_data = '0;
   logic          cfg_ready, cfg_busy, cfg_done;
   logic [0:NB-1] bl, wl;
   logic [3:0]    cfg_mux_idx;

   logic          start2 = 1'b0;
   logic          valid2 = 1'b0;
   logic [W-1:0]  data2 = '0;
   logic          ready2, busy2, done2;
   logic [0:NB-1] bl2, wl2;
   logic [3:0]    idx2;

   cb_cfg_loader dut (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .cfg_start   (cfg_start),
      .cfg_data    (cfg_data),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .bl          (bl),
      .wl          (wl),
      .cfg_mux_idx (cfg_mux_idx),
      .cfg_busy    (cfg_busy),
      .cfg_done    (cfg_done)
   );

   cb_cfg_loader #(
      .SETUP_CYC (2),
      .PULSE_CYC (1),
      .HOLD_CYC  (3)
   ) dut_sweep (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .cfg_start   (start2),
      .cfg_data    (data2),
      .cfg_valid   (valid2),
      .cfg_ready   (ready2),
      .bl          (bl2),
      .wl          (wl2),
      .cfg_mux_idx (idx2),
      .cfg_busy    (busy2),
      .cfg_done    (done2)
   );

   always #5 prog_clk = ~prog_clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [0:NB-1] slice_vec(input int idx, input logic [W-1:0] d);
      logic [0:NB-1] v;
      v = '0;
      for (int i = 0; i < W; i++) v[idx*W + i] = d[i];
      return v;
   endfunction

   function automatic logic [0:NB-1] ones_vec(input int idx);
      return slice_vec(idx, {W{1'b1}});
   endfunction

   // Scoreboard of accepted words, popped when the matching wl pulse appears.
   typedef struct {
      int           idx;
      logic [W-1:0] data;
      time          t;
   } wr_t;
   wr_t sb_q[$];

   // Reference model: session flags plus the fixed per-word latency.
   bit   m_session, m_done, m_inflight, m_start_pend, m_reset_pend;
   int   m_idx, m_pending_at;
   int   cyc = 0;
   bit   abort_pulse = 1'b0;
   int   done_rise_cyc = -1;
   logic done_prev = 1'b0;
   int   first_acc = -1;

   task automatic next_cycle();
      @(negedge prog_clk);
      cyc++;
      if (m_reset_pend) begin
         m_session = 0; m_done = 0; m_inflight = 0; m_start_pend = 0; m_idx = 0;
         m_reset_pend = 0;
         sb_q.delete();
      end
      if (m_start_pend) begin
         m_session = 1; m_done = 0; m_idx = 0; m_start_pend = 0;
      end
      if (m_inflight && cyc == m_pending_at) begin
         m_inflight = 0;
         m_idx++;
         if (m_idx == N) m_done = 1;
      end
      check("cfg_ready", cfg_ready, m_session && !m_done && !m_inflight);
      check("cfg_busy", cfg_busy, m_session && !m_done);
      check("cfg_done", cfg_done, m_done);
      check("cfg_mux_idx", cfg_mux_idx, m_idx);
      if (!m_inflight) begin
         check("bl_idle", bl, '0);
         check("wl_idle", wl, '0);
      end
      if (cfg_done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
      done_prev = cfg_done;
   endtask

   task automatic drive(input bit start, input bit valid, input logic [W-1:0] data, output bit xfer);
      cfg_start = start;
      cfg_valid = valid;
      cfg_data  = data;
      xfer      = 0;
      if (start) begin
         if (!m_inflight) m_start_pend = 1;
      end else if (valid && m_session && !m_done && !m_inflight) begin
         xfer = 1;
         sb_q.push_back('{m_idx, data, $time});
         m_inflight   = 1;
         m_pending_at = cyc + LAT;
      end
   endtask

   task automatic do_reset(input int n);
      bit x;
      drive(0, 0, '0, x);
      prog_reset = 1'b1;
      repeat (n) begin
         m_reset_pend = 1;
         next_cycle();
      end
      prog_reset = 1'b0;
   endtask

   task automatic do_start();
      bit x;
      drive(1, 0, '0, x);
      next_cycle();
      drive(0, 0, '0, x);
   endtask

   // mode: 0 random data, 1 data = word number + 1, 2 fixed 6'b101101
   task automatic run_words(input int n, input int duty, input int mode);
      int sent = 0;
      int spent = 0;
      bit x;
      logic [W-1:0] d;
      first_acc = -1;
      while ((sent < n || m_inflight) && spent < 2000) begin
         bit v;
         v = (sent < n) && ($urandom_range(99) < duty);
         d = (mode == 1) ? W'(sent + 1) : (mode == 2) ? 6'b101101 : W'($urandom);
         drive(0, v, d, x);
         if (x) begin
            if (sent == 0) first_acc = cyc;
            sent++;
         end
         next_cycle();
         spent++;
      end
      drive(0, 0, '0, x);
   endtask

   // Monitor: every wl pulse must be one full slice matching the next scoreboard entry.
   logic [0:NB-1] prev_bl = '0;
   bit            min_pulse = 0;
   int            mplen = 0;
   int            mk;
   bit            mok;
   wr_t           me;

   always @(negedge prog_clk) begin
      if (wl !== '0) begin
         mk  = -1;
         mok = 1;
         for (int j = 0; j < N; j++) begin
            if (wl[j*W +: W] === {W{1'b1}}) begin
               if (mk < 0) mk = j;
               else mok = 0;
            end else if (wl[j*W +: W] !== '0) begin
               mok = 0;
            end
         end
         check("wl_single_slice", mok, 1);
         if (!min_pulse) begin
            min_pulse = 1;
            mplen = 0;
            check("bl_stable_at_wl_rise", bl, prev_bl);
            if (sb_q.size() == 0) begin
               check("wl_pulse_expected", wl, '0);
            end else begin
               me = sb_q.pop_front();
               check("wl_slice", mk, me.idx);
               check("bl_word", bl, slice_vec(me.idx, me.data));
               check("wl_rise_delay", ($time - me.t) / 10, 2);
            end
         end else begin
            check("bl_stable_in_pulse", bl, prev_bl);
         end
         mplen++;
      end else if (min_pulse) begin
         min_pulse = 0;
         if (abort_pulse) abort_pulse = 0;
         else check("wl_pulse_len", mplen, PLEN);
      end
      prev_bl = bl;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit x;
      logic [W-1:0] d;
      logic [0:NB-1] exp_v;

      // Reset values.
      m_reset_pend = 1;
      repeat (3) begin
         m_reset_pend = 1;
         next_cycle();
      end
      prog_reset = 1'b0;

      // Single word 6'b101101 with default timing.
      do_start();
      run_words(1, 100, 2);

      // Reset in the middle of the pulse for word 2 (wl[12:17]).
      do_start();
      run_words(2, 100, 0);
      drive(0, 1, W'($urandom), x);
      next_cycle();
      drive(0, 0, '0, x);
      next_cycle();
      check("wl_mid_pulse", wl, ones_vec(2));
      abort_pulse = 1;
      do_reset(1);
      next_cycle();

      // Full session, valid held high, words 0x01..0x0B.
      do_start();
      done_rise_cyc = -1;
      run_words(N, 100, 1);
      check("done_latency", done_rise_cyc - first_acc, LAT * N);
      repeat (8) begin
         drive(0, 1, 6'h0C, x);
         next_cycle();
      end
      drive(0, 0, '0, x);

      // Back-pressure: 30% valid duty, random data.
      do_start();
      run_words(N, 30, 0);
      next_cycle();

      // Start during HOLD of word 3 is ignored; start with a transfer in IDLE drops the word.
      do_start();
      run_words(3, 100, 0);
      drive(0, 1, W'($urandom), x);
      next_cycle();
      drive(0, 0, '0, x);
      repeat (3) next_cycle();
      drive(1, 0, '0, x);
      next_cycle();
      drive(0, 0, '0, x);
      check("idx_after_hold_start", cfg_mux_idx, 4);
      drive(1, 1, W'($urandom), x);
      next_cycle();
      drive(0, 0, '0, x);
      repeat (6) next_cycle();

      // Timing sweep instance: setup 2, pulse 1, hold 3.
      start2 = 1'b1;
      @(negedge prog_clk);
      start2 = 1'b0;
      check("sw_ready_after_start", ready2, 1);
      for (int w = 0; w < 2; w++) begin
         d = W'($urandom);
         valid2 = 1'b1;
         data2 = d;
         for (int off = 1; off <= 7; off++) begin
            @(negedge prog_clk);
            if (off == 1) valid2 = 1'b0;
            exp_v = (off == 3) ? ones_vec(w) : '0;
            check("sw_wl", wl2, exp_v);
            exp_v = (off <= 6) ? slice_vec(w, d) : '0;
            check("sw_bl", bl2, exp_v);
            check("sw_ready", ready2, off == 7);
         end
         check("sw_idx", idx2, w + 1);
      end

      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cb_cfg_loader.md
Name: cb_cfg_loader

Overview:
- Memory-bank configuration sequencer for one connection block: cbx_1__0_, 11 size-6 routing muxes, 66 config bits, with flat per-bit bl/wl.
- Accepts one 6-bit mux config word per valid/ready handshake.
- Drives that word onto the mux's bl slice, then pulses the matching 6 wl lines with programmable setup/pulse/hold timing.
- Sits between the fabric programming front-end and the CB's bl/wl ports; reports busy/done per load session.

Parameters:
- NUM_MUX, 11, number of muxes in the CB (words per session).
- MUX_SRAM, 6, config bits per mux (word width).
- SETUP_CYC, 1, cycles bl is stable before wl rises (>=1).
- PULSE_CYC, 2, cycles wl is held high (>=1).
- HOLD_CYC, 1, cycles bl is held after wl falls (>=1).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- prog_reset  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle pulse; opens a session and clears the word index.
- cfg_data  in  MUX_SRAM  config word for the current mux; bit 0 maps to sram[0].
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- bl  out  NUM_MUX*MUX_SRAM  bit lines, indexed [0:65] as in the CB.
- wl  out  NUM_MUX*MUX_SRAM  word lines, indexed [0:65] as in the CB.
- cfg_mux_idx  out  4  index of the mux being / next to be written.
- cfg_busy  out  1  session open and not yet done.
- cfg_done  out  1  sticky; all NUM_MUX words written.

Behaviour:
- Reset values: state=OFF; bl=0; wl=0; cfg_ready=0; cfg_busy=0; cfg_done=0; cfg_mux_idx=0; timer=0.
- Reset mid-write forces wl=0 on the next edge; the partial write is abandoned.
- State OFF:
  - Waits for cfg_start.
  - cfg_start -> IDLE, idx=0, done=0, busy=1.
- State IDLE:
  - cfg_ready=1.
  - On valid&&ready: latch cfg_data into bl[idx*6 +: 6] (all other bl bits 0), timer=SETUP_CYC-1, go to SETUP.
- State SETUP:
  - wl=0, bl driven.
  - When timer==0: timer=PULSE_CYC-1, go to PULSE; otherwise decrement.
- State PULSE:
  - wl[idx*6 +: 6]=6'b111111; all other wl bits 0.
  - When timer==0: timer=HOLD_CYC-1, go to HOLD.
- State HOLD:
  - wl=0, bl held.
  - When timer==0: clear bl and increment idx.
  - If new idx==NUM_MUX: go to DONE (done=1, busy=0). Otherwise go to IDLE.
- State DONE:
  - cfg_ready=0; extra words are not accepted (held off by handshake).
  - cfg_start -> IDLE with idx=0, done=0.
- Handshake:
  - Transfer only when cfg_valid && cfg_ready are both high in the same cycle.
  - cfg_ready is a registered function of state only, never combinational on cfg_valid.
  - cfg_data is sampled only on a transfer cycle.
- Per-word latency, accept edge to ready high again: SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles. Defaults give 5; a session is 11 words = 55 cycles minimum.
- Invariants:
  - At most 6 wl bits high at any time, always within one mux slice.
  - wl never rises in the same cycle bl changes.
  - bl stays stable from SETUP through the end of HOLD.
- cfg_start while in SETUP/PULSE/HOLD: ignored. The in-flight write completes; start has no effect on the word index.
- cfg_start in the same cycle as a transfer in IDLE: start wins; the word is not accepted and idx resets to 0.
- Width rules:
  - cfg_mux_idx is 4 bits, so NUM_MUX<=15; elaboration check.
  - Slice base = idx*MUX_SRAM, computed in an unsigned width wide enough for NUM_MUX*MUX_SRAM-1.

Decomposition:
- Package cb_cfg_pkg:
  - State enum {OFF, IDLE, SETUP, PULSE, HOLD, DONE}.
  - Localparam TIMER_W = clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)).
  - Function slice_base(idx).
- One natural sub-module: cb_cfg_timer, a loadable down-counter with a zero flag, shared by the SETUP/PULSE/HOLD phases.
- bl/wl one-hot-slice decode stays in the top module.

Test Plan:
- Reset mid-PULSE with wl[12:17]=1: assert prog_reset 1 cycle -> next edge wl=0, bl=0, cfg_busy=0, cfg_done=0, cfg_ready=0.
- cfg_start, then one word 6'b101101 with defaults:
  - bl[0:5]=101101 (sram[0]=1) from the cycle after accept.
  - wl[0:5] high exactly cycles +2..+3 after accept.
  - bl cleared at +5.
  - cfg_ready high again at +5; cfg_mux_idx=1.
- Full session of 11 words 0x01..0x0B with cfg_valid held high:
  - cfg_done=1 at cycle 55 after the first accept; cfg_busy=0 at the same time.
  - Word k lands only on bl/wl[6k:6k+5].
  - An extra 12th valid word is never accepted (cfg_ready stays 0).
- Back-pressure: cfg_valid random 30% duty -> every word written once, in order; no wl activity while IDLE.
- cfg_start during HOLD of word 3 -> ignored; word 3 completes, idx=4. cfg_start coinciding with a transfer in IDLE -> word dropped, idx=0.
- Parameter sweep SETUP_CYC=2, PULSE_CYC=1, HOLD_CYC=3 -> wl high for exactly 1 cycle, 2 cycles after the bl change; ready returns 7 cycles after accept.
